// File: rtl/register_file_if.sv
// Register-file access bundle: two combinational read ports and one synchronous write port.
interface register_file_if #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] read_reg1;
  logic [ADDR_W-1:0] read_reg2;
  logic [ADDR_W-1:0] write_reg;
  logic [XLEN-1:0]   write_data;
  logic              reg_write;
  logic [XLEN-1:0]   read_data1;
  logic [XLEN-1:0]   read_data2;

  modport master (
    output read_reg1, read_reg2, write_reg, write_data, reg_write,
    input  read_data1, read_data2
  );

  modport slave (
    input  read_reg1, read_reg2, write_reg, write_data, reg_write,
    output read_data1, read_data2
  );
endinterface

// File: rtl/register_file.sv
// 32 x XLEN RISC-V integer register file: asynchronous reads, synchronous write, x0 hardwired to zero.
// Optional same-cycle write-to-read forwarding when REGFILE_WRITE_BYPASS_EN is defined.
module register_file #(
  parameter int              XLEN     = 64,
  parameter int              NUM_REGS = 32,
  parameter int              ADDR_W   = 5,
  parameter logic [XLEN-1:0] SP_INIT  = 64'h0000_0000_0000_7FF0
) (
  input  logic          clk,
  input  logic          reset,
  register_file_if.slave rf
);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;

  // Reset wins over a concurrent write; x2 comes up holding the initial stack pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= (i == 2) ? SP_INIT : '0;
      end
    end else if (rf.reg_write && (rf.write_reg != '0)) begin
      regs[rf.write_reg] <= rf.write_data;
    end
  end

`ifdef REGFILE_WRITE_BYPASS_EN
  logic wr_fwd;
  assign wr_fwd = rf.reg_write && !reset && (rf.write_reg != '0);
`endif

  // x0 masking is applied last so it overrides both storage and forwarding.
  always_comb begin
    rd1 = regs[rf.read_reg1];
    rd2 = regs[rf.read_reg2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (wr_fwd && (rf.write_reg == rf.read_reg1)) rd1 = rf.write_data;
    if (wr_fwd && (rf.write_reg == rf.read_reg2)) rd2 = rf.write_data;
`endif
    if (rf.read_reg1 == '0) rd1 = '0;
    if (rf.read_reg2 == '0) rd2 = '0;
  end

  assign rf.read_data1 = rd1;
  assign rf.read_data2 = rd2;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios followed by randomized traffic
// against an array-based reference model.
module tb_register_file;

  localparam int              XLEN    = 64;
  localparam int              ADDR_W  = 5;
  localparam logic [XLEN-1:0] SP_INIT = 64'h0000_0000_0000_7FF0;

  logic clk;
  logic reset;

  register_file_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) rf_bus ();

  register_file #(
    .XLEN    (XLEN),
    .NUM_REGS(32),
    .ADDR_W  (ADDR_W),
    .SP_INIT (SP_INIT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (rf_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] model [32];

  task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // What a read port must show for the currently driven inputs.
  function automatic logic [XLEN-1:0] expect_read(input int idx);
    if (idx == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (rf_bus.reg_write && !reset && rf_bus.write_reg != 0 && int'(rf_bus.write_reg) == idx)
      return rf_bus.write_data;
`endif
    return model[idx];
  endfunction

  function automatic void model_edge();
    if (reset) begin
      foreach (model[i]) model[i] = '0;
      model[2] = SP_INIT;
    end else if (rf_bus.reg_write && rf_bus.write_reg != 0) begin
      model[rf_bus.write_reg] = rf_bus.write_data;
    end
  endfunction

  // One clock: drive, check reads before the edge, clock, check reads after the edge.
  task automatic cycle(input string tag, input bit rst, input bit we, input int wr,
                       input logic [XLEN-1:0] wd, input int r1, input int r2, input bit pre_chk);
    reset              = rst;
    rf_bus.reg_write   = we;
    rf_bus.write_reg   = ADDR_W'(wr);
    rf_bus.write_data  = wd;
    rf_bus.read_reg1   = ADDR_W'(r1);
    rf_bus.read_reg2   = ADDR_W'(r2);
    #1;
    if (pre_chk) begin
      chk({tag, ".pre.rd1"}, rf_bus.read_data1, expect_read(r1));
      chk({tag, ".pre.rd2"}, rf_bus.read_data2, expect_read(r2));
    end
    @(posedge clk);
    model_edge();
    #1;
    chk({tag, ".post.rd1"}, rf_bus.read_data1, expect_read(r1));
    chk({tag, ".post.rd2"}, rf_bus.read_data2, expect_read(r2));
  endtask

  initial begin
    reset             = 1'b0;
    rf_bus.reg_write  = 1'b0;
    rf_bus.write_reg  = '0;
    rf_bus.write_data = '0;
    rf_bus.read_reg1  = '0;
    rf_bus.read_reg2  = '0;
    foreach (model[i]) model[i] = 'x;

    // Reset with a competing write to x5; storage content is unknown beforehand.
    cycle("rst", 1, 1, 5, 64'hDEAD, 5, 2, 0);
    chk("rst.x5", rf_bus.read_data1, 64'h0);
    chk("rst.sp", rf_bus.read_data2, 64'h7FF0);
    cycle("rst31", 0, 0, 0, 0, 31, 2, 1);
    chk("rst.x31", rf_bus.read_data1, 64'h0);

    // Back-to-back writes.
    cycle("wr10", 0, 1, 10, 64'h1234_5678_9ABC_DEF0, 10, 11, 1);
    chk("wr.x10", rf_bus.read_data1, 64'h1234_5678_9ABC_DEF0);
    cycle("wr11", 0, 1, 11, 64'hFFFF_FFFF_FFFF_FFFF, 10, 11, 1);
    chk("wr.x11", rf_bus.read_data2, 64'hFFFF_FFFF_FFFF_FFFF);

    // x0 cannot be written and always reads zero.
    cycle("x0", 0, 1, 0, 64'hABCD, 0, 0, 1);
    chk("x0.rd1", rf_bus.read_data1, 64'h0);
    chk("x0.rd2", rf_bus.read_data2, 64'h0);

    // Disabled write leaves x7 alone.
    cycle("x7set", 0, 1, 7, 64'h99, 7, 7, 1);
    cycle("wdis", 0, 0, 7, 64'h55, 7, 7, 1);
    chk("wdis.x7", rf_bus.read_data1, 64'h99);

    // Same-cycle read/write of x3.
    cycle("x3old", 0, 1, 3, 64'h1, 3, 0, 1);
    reset = 0; rf_bus.reg_write = 1; rf_bus.write_reg = 3; rf_bus.write_data = 64'h2;
    rf_bus.read_reg1 = 3; rf_bus.read_reg2 = 3;
    #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    chk("x3.same.pre", rf_bus.read_data1, 64'h2);
`else
    chk("x3.same.pre", rf_bus.read_data1, 64'h1);
`endif
    cycle("x3new", 0, 1, 3, 64'h2, 3, 3, 1);
    chk("x3.same.post", rf_bus.read_data1, 64'h2);

    // Reset mid-stream discards a pending write to x4.
    cycle("x4set", 0, 1, 4, 64'h77, 4, 2, 1);
    cycle("x4rst", 1, 1, 4, 64'h88, 4, 2, 1);
    chk("midrst.x4", rf_bus.read_data1, 64'h0);
    chk("midrst.sp", rf_bus.read_data2, SP_INIT);

    // Randomized traffic; read indices are biased toward the write index to exercise collisions.
    for (int n = 0; n < 400; n++) begin
      bit              rst_r;
      bit              we_r;
      int              wr_r, r1_r, r2_r;
      logic [XLEN-1:0] wd_r;
      rst_r = ($urandom_range(0, 39) == 0);
      we_r  = ($urandom_range(0, 3) != 0);
      wr_r  = $urandom_range(0, 31);
      wd_r  = {$urandom, $urandom};
      r1_r  = ($urandom_range(0, 3) == 0) ? wr_r : $urandom_range(0, 31);
      r2_r  = ($urandom_range(0, 3) == 0) ? wr_r : $urandom_range(0, 31);
      cycle("rand", rst_r, we_r, wr_r, wd_r, r1_r, r2_r, 1);
    end

    // Sweep every register on both ports against the model.
    rf_bus.reg_write = 0;
    reset = 0;
    for (int i = 0; i < 32; i++) begin
      rf_bus.read_reg1 = ADDR_W'(i);
      rf_bus.read_reg2 = ADDR_W'(31 - i);
      #1;
      chk("sweep.rd1", rf_bus.read_data1, expect_read(i));
      chk("sweep.rd2", rf_bus.read_data2, expect_read(31 - i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
